// File: rtl/exu_arbiter.sv
// Round-robin arbiter/sequencer sharing one combinational EXU among NUM_REQ requesters.
// Optional illegal-op flagging on resp_err is enabled by defining EXU_ARB_ILLEGAL_OP_EN.
module exu_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [5*NUM_REQ-1:0]    req_op,
    input  logic [32*NUM_REQ-1:0]   req_a,
    input  logic [32*NUM_REQ-1:0]   req_b,
    input  logic [5*NUM_REQ-1:0]    req_waddr,
    input  logic [NUM_REQ-1:0]      req_wen,
    output logic [4:0]              exu_op,
    output logic [31:0]             exu_a,
    output logic [31:0]             exu_b,
    output logic                    exu_wen,
    output logic [4:0]              exu_waddr,
    input  logic [31:0]             exu_result,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [31:0]             resp_data,
    output logic [4:0]              resp_waddr,
    output logic                    resp_wen,
    output logic [ID_W-1:0]         resp_id,
    output logic                    resp_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_RESP
    } state_e;

    state_e            state_q, state_d;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [4:0]        iss_op_q, iss_op_d;
    logic [31:0]       iss_a_q, iss_a_d;
    logic [31:0]       iss_b_q, iss_b_d;
    logic [4:0]        iss_waddr_q, iss_waddr_d;
    logic              iss_wen_q, iss_wen_d;
    logic [ID_W-1:0]   iss_id_q, iss_id_d;
    logic              resp_valid_q, resp_valid_d;
    logic [31:0]       resp_data_q, resp_data_d;
    logic [4:0]        resp_waddr_q, resp_waddr_d;
    logic              resp_wen_q, resp_wen_d;
    logic [ID_W-1:0]   resp_id_q, resp_id_d;
    logic              resp_err_q, resp_err_d;

    logic              win_vld;
    logic [ID_W-1:0]   win_id;
    logic              accept;
    int                idx;

    // First valid requester at or after rr_ptr, wrapping at NUM_REQ-1.
    always_comb begin
        win_vld = 1'b0;
        win_id  = '0;
        idx     = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!win_vld && req_valid[idx]) begin
                win_vld = 1'b1;
                win_id  = ID_W'(idx);
            end
        end
    end

    assign accept = (state_q == S_IDLE) && win_vld;

    always_comb begin
        req_ready = '0;
        if (rst_n && accept) req_ready[win_id] = 1'b1;
    end

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        iss_op_d     = iss_op_q;
        iss_a_d      = iss_a_q;
        iss_b_d      = iss_b_q;
        iss_waddr_d  = iss_waddr_q;
        iss_wen_d    = iss_wen_q;
        iss_id_d     = iss_id_q;
        resp_valid_d = resp_valid_q;
        resp_data_d  = resp_data_q;
        resp_waddr_d = resp_waddr_q;
        resp_wen_d   = resp_wen_q;
        resp_id_d    = resp_id_q;
        resp_err_d   = resp_err_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    iss_op_d    = req_op[5*win_id +: 5];
                    iss_a_d     = req_a[32*win_id +: 32];
                    iss_b_d     = req_b[32*win_id +: 32];
                    iss_waddr_d = req_waddr[5*win_id +: 5];
                    iss_wen_d   = req_wen[win_id];
                    iss_id_d    = win_id;
                    rr_ptr_d    = (win_id == ID_W'(NUM_REQ - 1)) ?
                                  '0 : win_id + ID_W'(1);
                    state_d     = S_EXEC;
                end
            end
            S_EXEC: begin
                resp_data_d  = exu_result;
                resp_waddr_d = iss_waddr_q;
                resp_wen_d   = iss_wen_q;
                resp_id_d    = iss_id_q;
`ifdef EXU_ARB_ILLEGAL_OP_EN
                resp_err_d   = (iss_op_q > 5'd7);
`else
                resp_err_d   = 1'b0;
`endif
                resp_valid_d = 1'b1;
                state_d      = S_RESP;
            end
            S_RESP: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    state_d      = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            rr_ptr_q     <= '0;
            iss_op_q     <= '0;
            iss_a_q      <= '0;
            iss_b_q      <= '0;
            iss_waddr_q  <= '0;
            iss_wen_q    <= 1'b0;
            iss_id_q     <= '0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            resp_waddr_q <= '0;
            resp_wen_q   <= 1'b0;
            resp_id_q    <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            iss_op_q     <= iss_op_d;
            iss_a_q      <= iss_a_d;
            iss_b_q      <= iss_b_d;
            iss_waddr_q  <= iss_waddr_d;
            iss_wen_q    <= iss_wen_d;
            iss_id_q     <= iss_id_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            resp_waddr_q <= resp_waddr_d;
            resp_wen_q   <= resp_wen_d;
            resp_id_q    <= resp_id_d;
            resp_err_q   <= resp_err_d;
        end
    end

    assign exu_op     = iss_op_q;
    assign exu_a      = iss_a_q;
    assign exu_b      = iss_b_q;
    assign exu_wen    = iss_wen_q;
    assign exu_waddr  = iss_waddr_q;
    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;
    assign resp_waddr = resp_waddr_q;
    assign resp_wen   = resp_wen_q;
    assign resp_id    = resp_id_q;
    assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_exu_arbiter.sv
// Scoreboard bench for exu_arbiter with a behavioural EXU and round-robin model.
// Define EXU_ARB_ILLEGAL_OP_EN to also exercise illegal-op flagging.
module tb_exu_arbiter;

    localparam int N  = 4;
    localparam int IW = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [N-1:0]      req_valid = '0;
    logic [N-1:0]      req_ready;
    logic [5*N-1:0]    req_op = '0;
    logic [32*N-1:0]   req_a = '0;
    logic [32*N-1:0]   req_b = '0;
    logic [5*N-1:0]    req_waddr = '0;
    logic [N-1:0]      req_wen = '0;
    logic [4:0]        exu_op;
    logic [31:0]       exu_a, exu_b;
    logic              exu_wen;
    logic [4:0]        exu_waddr;
    logic [31:0]       exu_result;
    logic              resp_valid;
    logic              resp_ready = 1'b1;
    logic [31:0]       resp_data;
    logic [4:0]        resp_waddr;
    logic              resp_wen;
    logic [IW-1:0]     resp_id;
    logic              resp_err;

    exu_arbiter #(.NUM_REQ(N), .ID_W(IW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .req_waddr(req_waddr), .req_wen(req_wen),
        .exu_op(exu_op), .exu_a(exu_a), .exu_b(exu_b),
        .exu_wen(exu_wen), .exu_waddr(exu_waddr),
        .exu_result(exu_result),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .resp_waddr(resp_waddr),
        .resp_wen(resp_wen), .resp_id(resp_id), .resp_err(resp_err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] alu(input logic [4:0] op,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
        case (op)
            5'd0: return a + b;
            5'd1: return a - b;
            5'd2: return a & b;
            5'd3: return a | b;
            5'd4: return a ^ b;
            5'd5: return a << b[4:0];
            5'd6: return a >> b[4:0];
            5'd7: return 32'($signed(a) >>> b[4:0]);
            default: return 32'd0;
        endcase
    endfunction

    assign exu_result = alu(exu_op, exu_a, exu_b);

    typedef struct {
        logic [31:0] data;
        logic [4:0]  waddr;
        logic        wen;
        int          id;
        logic        err;
        int          acc;
    } exp_t;

    exp_t  sb[$];
    int    dut_grants[$];
    int    errors = 0;
    int    checks = 0;
    int    cyc = 0;
    int    resp_cnt = 0;
    logic [31:0] last_data;
    logic [4:0]  last_waddr;
    logic        last_wen;
    int          last_id;
    logic        last_err;

    int  ptr = 0;
    bit  busy = 0;
    int  acc_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)",
                     name, act, exp, $time);
        end
    endtask

    // Response monitor: pops the scoreboard on each handshake.
    logic        prv_v = 1'b0;
    logic        prv_stall = 1'b0;
    logic [71:0] prv_vec;
    always @(negedge clk) begin
        if (rst_n) begin
            if (|(req_valid & req_ready)) begin
                for (int i = 0; i < N; i++)
                    if (req_valid[i] & req_ready[i]) dut_grants.push_back(i);
            end
            if (resp_valid && !prv_v) begin
                chk("resp_pending", 64'(sb.size() > 0), 64'd1);
                if (sb.size() > 0) chk("latency", cyc, sb[0].acc + 2);
            end
            if (prv_stall)
                chk("stall_stable",
                    {resp_valid, resp_data, resp_waddr, resp_wen,
                     30'(resp_id), resp_err, 3'b0},
                    prv_vec);
            if (resp_valid && resp_ready && sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                chk("resp_data", resp_data, e.data);
                chk("resp_waddr", resp_waddr, e.waddr);
                chk("resp_wen", resp_wen, e.wen);
                chk("resp_id", resp_id, e.id);
                chk("resp_err", resp_err, e.err);
                last_data  = resp_data;
                last_waddr = resp_waddr;
                last_wen   = resp_wen;
                last_id    = int'(resp_id);
                last_err   = resp_err;
                resp_cnt++;
            end
            prv_v     = resp_valid;
            prv_stall = resp_valid && !resp_ready;
            prv_vec   = {resp_valid, resp_data, resp_waddr, resp_wen,
                         30'(resp_id), resp_err, 3'b0};
        end else begin
            prv_v     = 1'b0;
            prv_stall = 1'b0;
        end
    end

    // One cycle of the reference model; returns at posedge+1.
    task automatic step();
        logic [N-1:0] exp_rdy;
        int  w;
        bit  rel;
        exp_t e;
        @(negedge clk);
        exp_rdy = '0;
        w = -1;
        if (!busy)
            for (int k = 0; k < N; k++)
                if (w < 0 && req_valid[(ptr + k) % N]) w = (ptr + k) % N;
        if (w >= 0) exp_rdy[w] = 1'b1;
        chk("req_ready", req_ready, exp_rdy);
        rel = busy && (cyc >= acc_cyc + 2) && resp_ready;
        if (w >= 0) begin
            e.waddr = req_waddr[5*w +: 5];
            e.wen   = req_wen[w];
            e.id    = w;
            e.data  = alu(req_op[5*w +: 5], req_a[32*w +: 32],
                          req_b[32*w +: 32]);
`ifdef EXU_ARB_ILLEGAL_OP_EN
            e.err   = (req_op[5*w +: 5] > 5'd7);
`else
            e.err   = 1'b0;
`endif
            e.acc   = cyc;
            sb.push_back(e);
            ptr     = (w + 1) % N;
            busy    = 1;
            acc_cyc = cyc;
        end
        @(posedge clk);
        #1;
        if (rel) busy = 0;
        if (w >= 0) req_valid[w] = 1'b0;
    endtask

    task automatic set_req(input int i, input logic [4:0] op,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] wa, input logic we);
        req_op[5*i +: 5]     = op;
        req_a[32*i +: 32]    = a;
        req_b[32*i +: 32]    = b;
        req_waddr[5*i +: 5]  = wa;
        req_wen[i]           = we;
        req_valid[i]         = 1'b1;
    endtask

    task automatic wait_resp(input string name);
        int start;
        bit got;
        start = resp_cnt;
        got = 0;
        for (int k = 0; k < 12 && !got; k++) begin
            step();
            if (resp_cnt > start) got = 1;
        end
        chk(name, 64'(got), 64'd1);
    endtask

    logic [31:0] sweep_exp [1:7];

    initial begin
        sweep_exp[1] = 32'hEFFF_FFFC;
        sweep_exp[2] = 32'h0000_0000;
        sweep_exp[3] = 32'hF000_0004;
        sweep_exp[4] = 32'hF000_0004;
        sweep_exp[5] = 32'h0000_0000;
        sweep_exp[6] = 32'h0F00_0000;
        sweep_exp[7] = 32'hFF00_0000;

        #3;
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_data", resp_data, 0);
        chk("rst_resp_id", resp_id, 0);
        chk("rst_resp_err", resp_err, 0);
        chk("rst_exu_a", exu_a, 0);
        chk("rst_req_ready", req_ready, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single request from requester 2
        set_req(2, 5'd0, 32'd5, 32'd7, 5'd3, 1'b1);
        wait_resp("t1_timeout");
        chk("t1_data", last_data, 32'd12);
        chk("t1_id", last_id, 2);
        chk("t1_waddr", last_waddr, 5'd3);
        chk("t1_wen", last_wen, 1'b1);

        // Op sweep
        for (int op = 1; op <= 7; op++) begin
            set_req(0, 5'(op), 32'hF000_0000, 32'd4, 5'(op), 1'b0);
            wait_resp("sweep_timeout");
            chk($sformatf("sweep_op%0d", op), last_data, sweep_exp[op]);
        end

        // Backpressure
        resp_ready = 1'b0;
        set_req(3, 5'd4, 32'h1234_5678, 32'hFFFF_0000, 5'd9, 1'b1);
        repeat (3) step();
        set_req(0, 5'd0, 32'd1, 32'd1, 5'd1, 1'b1);
        set_req(1, 5'd0, 32'd2, 32'd2, 5'd2, 1'b1);
        repeat (10) step();
        chk("bp_held", resp_valid, 1'b1);
        resp_ready = 1'b1;
        step();
        step();
        chk("bp_next_accept", dut_grants[dut_grants.size()-1], 0);
        req_valid = '0;
        repeat (4) step();
        resp_cnt = resp_cnt;

        // Reset mid-operation
        set_req(1, 5'd0, 32'd100, 32'd200, 5'd7, 1'b1);
        begin
            bit acc_seen;
            acc_seen = 0;
            for (int k = 0; k < 8 && !acc_seen; k++) begin
                step();
                if (busy) acc_seen = 1;
            end
            chk("rst_mid_accept", 64'(acc_seen), 64'd1);
        end
        rst_n = 1'b0;
        #1;
        chk("rmid_exu_op", exu_op, 0);
        chk("rmid_exu_a", exu_a, 0);
        chk("rmid_exu_b", exu_b, 0);
        chk("rmid_exu_waddr", exu_waddr, 0);
        chk("rmid_resp_valid", resp_valid, 0);
        req_valid = '0;
        sb.delete();
        busy = 0;
        ptr  = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("rst_stale", resp_valid, 1'b0);
        end

        // Fairness: everyone valid all the time
        dut_grants.delete();
        for (int k = 0; k < 40 && dut_grants.size() < 5; k++) begin
            for (int i = 0; i < N; i++)
                if (!req_valid[i])
                    set_req(i, 5'($urandom_range(0, 7)), $urandom,
                            $urandom, 5'($urandom), 1'($urandom));
            step();
        end
        chk("fair_count", 64'(dut_grants.size() >= 5), 64'd1);
        for (int i = 0; i < 5 && i < dut_grants.size(); i++)
            chk($sformatf("fair_g%0d", i), dut_grants[i], i % N);
        req_valid = '0;
        repeat (6) step();

`ifdef EXU_ARB_ILLEGAL_OP_EN
        set_req(2, 5'd9, 32'd3, 32'd4, 5'd5, 1'b1);
        wait_resp("ill_timeout");
        chk("ill_data", last_data, 0);
        chk("ill_err", last_err, 1'b1);
        set_req(2, 5'd0, 32'd3, 32'd4, 5'd5, 1'b1);
        wait_resp("ill2_timeout");
        chk("ill2_data", last_data, 32'd7);
        chk("ill2_err", last_err, 1'b0);
`endif

        // Randomized traffic
        for (int c = 0; c < 800; c++) begin
            resp_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i]) begin
                    if ($urandom_range(0, 2) == 0)
                        set_req(i, 5'($urandom_range(0, 9)), $urandom,
                                $urandom, 5'($urandom), 1'($urandom));
                end else if ($urandom_range(0, 11) == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
            step();
        end
        req_valid  = '0;
        resp_ready = 1'b1;
        repeat (10) step();
        chk("sb_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/exu_arbiter.md
# exu_arbiter

Round-robin arbiter and sequencer that shares one EXU (combinational ALU) among `NUM_REQ` requesters. It accepts one operation at a time through a valid/ready handshake and drives the latched operands into the EXU. The EXU result is captured into a response register, tagged with the requester index. The block sits between the decode-side requesters (integer pipe, address generator, debug port) and the single EXU instance.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesters; 2..8.
- `ID_W`, default 2: width of requester index; must satisfy 2^ID_W ≥ NUM_REQ.

Ports (clock and reset first):
- `clk`  in  1  clock; all state updates on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  NUM_REQ  per-requester request valid.
- `req_ready`  out  NUM_REQ  per-requester accept; one-hot or zero.
- `req_op`  in  5*NUM_REQ  packed ALU op codes; requester i is bits [5i+4:5i].
- `req_a`, `req_b`  in  32*NUM_REQ  packed operands A and B.
- `req_waddr`  in  5*NUM_REQ  packed destination register address.
- `req_wen`  in  NUM_REQ  destination write enable.
- `exu_op`  out  5  to EXU op.
- `exu_a`, `exu_b`  out  32  to EXU operand A and operand B.
- `exu_wen`  out  1  to EXU write enable.
- `exu_waddr`  out  5  to EXU write address.
- `exu_result`  in  32  EXU result, combinational on the `exu_*` outputs.
- `resp_valid`  out  1  response valid.
- `resp_ready`  in  1  response consumer ready.
- `resp_data`  out  32  captured result.
- `resp_waddr`  out  5  captured destination address.
- `resp_wen`  out  1  captured write enable.
- `resp_id`  out  ID_W  index of the requester that was served.
- `resp_err`  out  1  illegal op flag; held 0 when `EXU_ARB_ILLEGAL_OP_EN` is undefined.

## Operation
- FSM states: IDLE → EXEC → RESP → IDLE.
- IDLE:
  - Winner is the first requester with `req_valid`=1, searching upward from `rr_ptr` with wrap at NUM_REQ−1→0.
  - `req_ready` is asserted only to the winner. When no requester is valid, `req_ready`=0.
  - Accept is `req_valid[i]&req_ready[i]`. On accept: latch op, a, b, waddr, wen and id into issue registers; set `rr_ptr` = (winner+1) mod NUM_REQ; go to EXEC.
- EXEC:
  - `exu_*` outputs come from the issue registers. In IDLE and RESP they also come from the issue registers, which hold their values.
  - On the next edge: `resp_data`←`exu_result` and the response fields are loaded from the issue registers; `resp_valid`←1; go to RESP.
- RESP:
  - `resp_*` outputs hold stable while `resp_valid`=1 and `resp_ready`=0.
  - On `resp_valid&resp_ready`: `resp_valid`←0; go to IDLE.
  - No new accept is allowed in the same cycle as the response handshake.
- `req_ready` is 0 in EXEC and RESP.
- `rr_ptr` changes only on accept.
- Requesters must hold their request fields stable while `req_valid`=1 and not accepted. Dropping `req_valid` before accept is allowed; that requester is simply not granted.

## Timing
- Reset (`rst_n`=0, asynchronous) sets: state=IDLE, `rr_ptr`=0, all issue registers 0, `resp_valid`=0, `resp_data`=0, `resp_waddr`=0, `resp_wen`=0, `resp_id`=0, `resp_err`=0.
- Consequence: `exu_op`/`exu_a`/`exu_b`/`exu_waddr`/`exu_wen` read 0 while in reset.
- Latency: accept at edge T; `resp_valid`=1 after edge T+1.
- Throughput: at most one operation per 3 cycles (accept, capture, handshake).
- Reset asserted mid-operation discards the in-flight op; no response is produced for it.
- `resp_ready` held 0 stalls the block indefinitely, and no request is accepted during the stall.

## Configuration
- Macro: `EXU_ARB_ILLEGAL_OP_EN`.
- Defined:
  - An op > 5'd7 is still accepted and sequenced normally.
  - The EXU returns 0 for such ops, so `resp_data`=0.
  - `resp_err`=1 for that response only.
- Undefined: no op checking; `resp_err` is tied 0.

## Test plan
- Single request: requester 2 sends op=0, a=5, b=7, waddr=3, wen=1 with `resp_ready`=1 → `resp_valid` after 2 edges with `resp_data`=12, `resp_id`=2, `resp_waddr`=3, `resp_wen`=1.
- Round-robin fairness: all 4 requesters held valid → grant order 0,1,2,3,0; each requester served once per 4 responses.
- Backpressure: `resp_ready`=0 for 10 cycles after a response → `resp_*` stable and `req_ready`=0 throughout; releasing `resp_ready` → IDLE, next accept one cycle later.
- Op sweep: ops 1–7 with a=0xF0000000 and b=4 → results 0xEFFFFFFC, 0, 0xF0000004, 0xF0000004, 0x00000000, 0x0F000000, 0xFF000000.
- Reset mid-op: assert `rst_n`=0 during EXEC → all outputs 0 immediately; after release, no stale response and `rr_ptr`=0.
- With `EXU_ARB_ILLEGAL_OP_EN` defined, op=5'd9 → `resp_data`=0 and `resp_err`=1; the following op=0 response has `resp_err`=0.
